// File: rtl/ram16k_burst_writer.sv
// Streams valid/ready words into ram16k at consecutive (wrapping) addresses
// from a programmed base, pulsing done once the final word has been committed.
module ram16k_burst_writer #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] value,
  output logic              load,
  output logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_reg;
  logic [DATA_W-1:0]   value_reg;
  logic                load_reg;
  logic [ADDR_W-1:0]   address_reg;
  logic [ADDR_W-1:0]   cur_addr_reg;
  logic [ADDR_W:0]     remaining_reg;
  logic [ADDR_W:0]     words_written_reg;
  logic [ADDR_W:0]     length_clamped;
  logic                transfer;

  // Anything beyond the full address space would rewrite locations twice.
  assign length_clamped = (length > MAX_LEN) ? MAX_LEN : length;

  assign in_ready      = (state_reg == RUN) && (remaining_reg != '0);
  assign transfer      = in_ready && in_valid;
  assign value         = value_reg;
  assign load          = load_reg;
  assign address       = address_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign words_written = words_written_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      value_reg         <= '0;
      load_reg          <= 1'b0;
      address_reg       <= '0;
      cur_addr_reg      <= '0;
      remaining_reg     <= '0;
      words_written_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          load_reg <= 1'b0;
          if (start) begin
            cur_addr_reg      <= base_addr;
            remaining_reg     <= length_clamped;
            words_written_reg <= '0;
            state_reg         <= (length_clamped != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (transfer) begin
            value_reg         <= in_data;
            address_reg       <= cur_addr_reg;
            load_reg          <= 1'b1;
            cur_addr_reg      <= cur_addr_reg + 1'b1;
            remaining_reg     <= remaining_reg - 1'b1;
            words_written_reg <= words_written_reg + 1'b1;
            if (remaining_reg == {{ADDR_W{1'b0}}, 1'b1}) begin
              state_reg <= FLUSH;
            end
          end else begin
            load_reg <= 1'b0;
          end
        end
        // The last word's load is still asserted here; ram16k commits it at this edge.
        FLUSH: begin
          load_reg  <= 1'b0;
          state_reg <= DONE;
        end
        DONE: begin
          load_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          load_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram16k_burst_writer.sv
// Bench for ram16k_burst_writer: a behavioural ram16k stand-in, a vector table
// for single bursts, and hand-written sequences for reset, start-while-busy and clamp.
module tb_ram16k_burst_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] base_addr;
  logic [14:0] length;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] value;
  logic        load;
  logic [13:0] address;
  logic        busy;
  logic        done;
  logic [14:0] words_written;

  always #5 clk = ~clk;

  ram16k_burst_writer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .value(value), .load(load), .address(address),
    .busy(busy), .done(done), .words_written(words_written)
  );

  // ram16k stand-in plus a per-address write counter
  logic [15:0] mem  [16384];
  int          wcnt [16384];
  logic        clr = 1'b0;

  always @(posedge clk) begin
    if (clr) begin
      foreach (wcnt[i]) wcnt[i] <= 0;
    end else if (load === 1'b1) begin
      mem[address]  <= value;
      wcnt[address] <= wcnt[address] + 1;
    end
  end

  typedef struct packed {
    logic [13:0]       base;
    logic [14:0]       len;
    logic [15:0]       pat;
    logic [2:0][15:0]  data;
    logic [2:0][13:0]  addr;
    int                busy_cyc;
    int                ready_cyc;
    int                gap;
  } vec_t;

  vec_t vec [4];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_vec(input int i, input logic [13:0] b, input logic [14:0] l,
                         input logic [15:0] p, input logic [15:0] d0, d1, d2,
                         input logic [13:0] a0, a1, a2, input int bc, rc, g);
    vec[i].base = b;  vec[i].len = l;  vec[i].pat = p;
    vec[i].data[0] = d0; vec[i].data[1] = d1; vec[i].data[2] = d2;
    vec[i].addr[0] = a0; vec[i].addr[1] = a1; vec[i].addr[2] = a2;
    vec[i].busy_cyc = bc; vec[i].ready_cyc = rc; vec[i].gap = g;
  endtask

  task automatic clear_counts();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  initial begin
    int nw, acc, busy_n, ready_n, done_n, done_cyc, last_acc, k, bad;
    vec_t v;

    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    in_data = '0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_load", load, 1'b0);
    check("rst_address", address, 14'd0);
    check("rst_value", value, 16'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_words_written", words_written, 15'd0);

    set_vec(0, 14'd4739, 15'd2, 16'hFFFF, 16'h0003, 16'h000F, 16'h0,
            14'd4739, 14'd4740, 14'd0, 4, 2, 2);
    set_vec(1, 14'd10861, 15'd3, 16'h0015, 16'h1111, 16'h2222, 16'h3333,
            14'd10861, 14'd10862, 14'd10863, 7, 5, 2);
    set_vec(2, 14'd16383, 15'd3, 16'hFFFF, 16'hAAAA, 16'hBBBB, 16'hCCCC,
            14'd16383, 14'd0, 14'd1, 5, 3, 2);
    set_vec(3, 14'd77, 15'd0, 16'hFFFF, 16'h0, 16'h0, 16'h0,
            14'd0, 14'd0, 14'd0, 1, 0, 1);

    for (int t = 0; t < 4; t++) begin
      v = vec[t];
      clear_counts();
      nw = 0; acc = 0; busy_n = 0; ready_n = 0; done_n = 0; done_cyc = -1; last_acc = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
        @(negedge clk);
        if (cyc > 0 && !busy) break;
        if (load) begin
          if (nw < int'(v.len)) begin
            check($sformatf("v%0d_addr%0d", t, nw), address, v.addr[nw]);
            check($sformatf("v%0d_value%0d", t, nw), value, v.data[nw]);
          end else begin
            check($sformatf("v%0d_extra_write", t), nw, v.len);
          end
          nw++;
        end
        if (busy) busy_n++;
        if (in_ready) ready_n++;
        if (done) begin done_n++; done_cyc = cyc; end
        start     = (cyc == 0);
        base_addr = v.base;
        length    = v.len;
        in_valid  = (cyc > 0) ? v.pat[(cyc - 1) % 16] : 1'b0;
        in_data   = (acc < 3) ? v.data[acc] : 16'h0;
        if (in_valid && in_ready) begin acc++; last_acc = cyc; end
      end
      in_valid = 1'b0; start = 1'b0;
      check($sformatf("v%0d_write_count", t), nw, v.len);
      check($sformatf("v%0d_busy_cycles", t), busy_n, v.busy_cyc);
      check($sformatf("v%0d_ready_cycles", t), ready_n, v.ready_cyc);
      check($sformatf("v%0d_done_pulses", t), done_n, 1);
      check($sformatf("v%0d_done_gap", t), done_cyc - last_acc, v.gap);
      check($sformatf("v%0d_words_written", t), words_written, v.len);
      for (int i = 0; i < int'(v.len); i++) begin
        check($sformatf("v%0d_mem%0d", t, i), mem[v.addr[i]], v.data[i]);
        check($sformatf("v%0d_wcnt%0d", t, i), wcnt[v.addr[i]], 1);
      end
      $display("burst %0d base=%0d len=%0d writes=%0d done_gap=%0d", t, v.base, v.len, nw, done_cyc - last_acc);
    end

    // reset after two accepted words
    clear_counts();
    @(negedge clk); base_addr = 14'd100; length = 15'd4; start = 1'b1; in_valid = 1'b1; in_data = 16'h1000;
    @(negedge clk); start = 1'b0; in_data = 16'h1000;
    @(negedge clk); in_data = 16'h1001;
    @(negedge clk);
    check("rst_mid_ww_before", words_written, 15'd2);
    reset = 1'b1; in_data = 16'h1002;
    @(negedge clk); reset = 1'b0;
    check("rst_mid_load", load, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ready", in_ready, 1'b0);
    done_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) done_n++;
      if (load) done_n += 100;
    end
    in_valid = 1'b0;
    check("rst_mid_no_done_or_load", done_n, 0);
    check("rst_mid_mem100", mem[100], 16'h1000);
    check("rst_mid_mem101", mem[101], 16'h1001);
    check("rst_mid_wcnt102", wcnt[102], 0);
    check("rst_mid_wcnt103", wcnt[103], 0);
    $display("reset mid-burst: words_written=%0d busy=%0d", words_written, busy);

    // start pulsed during RUN must be ignored
    clear_counts();
    @(negedge clk); base_addr = 14'd2000; length = 15'd3; start = 1'b1; in_valid = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (!busy) break;
      start     = (cyc == 1);
      base_addr = (cyc == 1) ? 14'd500 : 14'd2000;
      length    = (cyc == 1) ? 15'd7 : 15'd3;
      in_data   = 16'h2000 + 16'(k);
      if (in_ready) k++;
    end
    start = 1'b0; in_valid = 1'b0;
    check("busy_start_wcnt500", wcnt[500], 0);
    check("busy_start_mem2000", mem[2000], 16'h2000);
    check("busy_start_mem2002", mem[2002], 16'h2002);
    check("busy_start_wcnt2003", wcnt[2003], 0);
    check("busy_start_ww", words_written, 15'd3);
    $display("start while busy: words_written=%0d", words_written);

    // start and reset together: reset wins
    @(negedge clk); reset = 1'b1; start = 1'b1; length = 15'd5;
    @(negedge clk); reset = 1'b0; start = 1'b0;
    check("start_reset_busy", busy, 1'b0);
    check("start_reset_ww", words_written, 15'd0);
    $display("start+reset: busy=%0d", busy);

    // oversize length clamps to a single pass over the whole array
    clear_counts();
    @(negedge clk); base_addr = 14'd5; length = 15'd20000; start = 1'b1; in_valid = 1'b1;
    @(negedge clk); start = 1'b0;
    nw = 0;
    for (int cyc = 0; cyc < 17000; cyc++) begin
      @(negedge clk);
      in_data = 16'(cyc);
      if (load) nw++;
      if (!busy) break;
    end
    in_valid = 1'b0;
    bad = 0;
    foreach (wcnt[i]) if (wcnt[i] != 1) bad++;
    check("clamp_writes", nw, 16384);
    check("clamp_ww", words_written, 15'd16384);
    check("clamp_each_once", bad, 0);
    check("clamp_idle", busy, 1'b0);
    $display("clamp: writes=%0d words_written=%0d", nw, words_written);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
